// File: rtl/ucie_protocol_rx_arbiter.sv
// Per-protocol FWFT ingress FIFOs feeding a packet-atomic weighted round-robin arbiter.
// At most one protocol is presented to the adapter, and it holds the grant until its EOP flit transfers.

module ucie_prx_fifo #(
    parameter int DW    = 265,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [DW-1:0]            wdata_i,
    output logic [DW-1:0]            rdata_o,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [DEPTH-1:0][DW-1:0] mem_q;
    logic [AW-1:0]            wr_q, rd_q;
    logic [AW:0]              level_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else if (flush_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
        end else begin
            if (push_i) wr_q <= wr_q + 1'b1;
            if (pop_i)  rd_q <= rd_q + 1'b1;
            level_q <= level_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
        end
    end

    // Storage needs no reset: the head is only observed while level is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_q];
    assign level_o = level_q;
endmodule

module ucie_protocol_rx_arbiter #(
    parameter int NUM_PROTOCOLS = 4,
    parameter int FLIT_W        = 256,
    parameter int FIFO_DEPTH    = 4,
    parameter int GID_W         = $clog2(NUM_PROTOCOLS)
) (
    input  logic                                          clk_i,
    input  logic                                          rst_ni,
    input  logic [NUM_PROTOCOLS-1:0][FLIT_W-1:0]          in_flit_i,
    input  logic [NUM_PROTOCOLS-1:0][7:0]                 in_vc_i,
    input  logic [NUM_PROTOCOLS-1:0]                      in_eop_i,
    input  logic [NUM_PROTOCOLS-1:0]                      in_valid_i,
    output logic [NUM_PROTOCOLS-1:0]                      in_ready_o,
    input  logic [NUM_PROTOCOLS-1:0]                      protocol_enable_i,
    input  logic [NUM_PROTOCOLS-1:0][7:0]                 protocol_weight_i,
    output logic [NUM_PROTOCOLS-1:0][FLIT_W-1:0]          out_flit_o,
    output logic [NUM_PROTOCOLS-1:0][7:0]                 out_vc_o,
    output logic [NUM_PROTOCOLS-1:0]                      out_valid_o,
    input  logic [NUM_PROTOCOLS-1:0]                      out_ready_i,
    output logic [GID_W-1:0]                              grant_id_o,
    output logic                                          grant_active_o,
    output logic [NUM_PROTOCOLS-1:0][$clog2(FIFO_DEPTH):0] fifo_level_o
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = FLIT_W + 9;

    typedef enum logic {IDLE, BURST} state_e;

    state_e                              state_q;
    logic [GID_W-1:0]                    grant_q, rr_q, hit_id;
    logic [7:0]                          credit_q;
    logic                                hit, pop_g, head_eop, last_pkt;
    logic [NUM_PROTOCOLS-1:0]            push, pop;
    logic [NUM_PROTOCOLS-1:0][DW-1:0]    rdata;
    logic [NUM_PROTOCOLS-1:0][LW-1:0]    level;

    for (genvar i = 0; i < NUM_PROTOCOLS; i++) begin : g_lane
        assign in_ready_o[i] = protocol_enable_i[i] && (level[i] < LW'(FIFO_DEPTH));
        assign push[i]       = in_valid_i[i] && in_ready_o[i];
        assign pop[i]        = pop_g && (grant_q == GID_W'(i));

        ucie_prx_fifo #(.DW(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk_i   (clk_i),
            .rst_ni  (rst_ni),
            .flush_i (!protocol_enable_i[i]),
            .push_i  (push[i]),
            .pop_i   (pop[i]),
            .wdata_i ({in_flit_i[i], in_vc_i[i], in_eop_i[i]}),
            .rdata_o (rdata[i]),
            .level_o (level[i])
        );

        wire sel = (state_q == BURST) && (grant_q == GID_W'(i));
        assign out_valid_o[i]  = sel && (level[i] != '0);
        assign out_flit_o[i]   = sel ? rdata[i][DW-1:9] : '0;
        assign out_vc_o[i]     = sel ? rdata[i][8:1]    : '0;
        assign fifo_level_o[i] = level[i];
    end

    // Round-robin scan starts one past the last granted protocol.
    always_comb begin
        hit    = 1'b0;
        hit_id = '0;
        for (int k = 1; k <= NUM_PROTOCOLS; k++) begin
            if (!hit && protocol_enable_i[(int'(rr_q) + k) % NUM_PROTOCOLS]
                     && level[(int'(rr_q) + k) % NUM_PROTOCOLS] != '0) begin
                hit    = 1'b1;
                hit_id = GID_W'((int'(rr_q) + k) % NUM_PROTOCOLS);
            end
        end
    end

    assign pop_g    = out_valid_o[grant_q] && out_ready_i[grant_q];
    assign head_eop = rdata[grant_q][0];
    assign last_pkt = (credit_q == 8'd1) || (level[grant_q] == LW'(1) && !push[grant_q]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= GID_W'(NUM_PROTOCOLS - 1);
            credit_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (hit) begin
                    grant_q  <= hit_id;
                    credit_q <= (protocol_weight_i[hit_id] == 8'd0) ? 8'd1 : protocol_weight_i[hit_id];
                    state_q  <= BURST;
                end
                BURST: begin
                    if (!protocol_enable_i[grant_q]) begin
                        rr_q    <= grant_q;
                        state_q <= IDLE;
                    end else if (pop_g && head_eop) begin
                        credit_q <= credit_q - 8'd1;
                        if (last_pkt) begin
                            rr_q    <= grant_q;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign grant_id_o     = grant_q;
    assign grant_active_o = (state_q == BURST);
endmodule
